// File: rtl/mxu_data_setup.sv
`default_nettype none
// ============================================================================
// Module   : mxu_data_setup
// Purpose  : Accepts tile beats (one operand per MAC row) over a valid/ready
//            handshake and skews them so row i sees its operand i cycles
//            after row 0. After the last beat of a tile the block drains the
//            skew pipeline, pulsing done on the cycle the final operand
//            reaches the last row.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous, active-low reset
//            s_valid    - upstream beat valid
//            s_ready    - block can accept a beat (low while draining)
//            s_data     - one operand per row, row i at [i*bit_width +: bit_width]
//            s_last     - final beat of a tile (sampled on accepted beats)
//            row_data   - skewed operands to the MAC rows, same packing
//            row_valid  - per-row qualifier for row_data
//            mac_ce     - MAC array clock enable, OR of row_valid
//            busy       - a tile is loading or draining
//            done       - one-cycle pulse in the final drain cycle
//            beat_cnt   - beats accepted in the current tile, saturating
// Revision : 1.0 - initial release
// ============================================================================
module mxu_data_setup #(
  parameter int bit_width = 4,
  parameter int n_rows    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [n_rows*bit_width-1:0]   s_data,
  input  logic                          s_last,
  output logic [n_rows*bit_width-1:0]   row_data,
  output logic [n_rows-1:0]             row_valid,
  output logic                          mac_ce,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    beat_cnt
);

  localparam int                 C_CNT_W      = $clog2(n_rows);
  localparam logic [C_CNT_W-1:0] C_DRAIN_LOAD = C_CNT_W'(n_rows - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [C_CNT_W-1:0]   r_drain_cnt;
  logic [7:0]           r_beat_cnt;
  logic                 w_accept;
  logic                 w_drain_last;

  assign s_ready      = (r_state != ST_DRAIN);
  assign w_accept     = s_valid && s_ready;
  // Drain runs n_rows cycles, so its last cycle lines up with the final
  // beat's operand arriving on the last row.
  assign w_drain_last = (r_state == ST_DRAIN) && (r_drain_cnt == '0);
  assign busy         = (r_state != ST_IDLE);
  assign done         = w_drain_last;
  assign beat_cnt     = r_beat_cnt;
  assign mac_ce       = |row_valid;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = s_last ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept && s_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Drain counter: loaded on the edge that enters DRAIN, counts down to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drain_cnt <= '0;
    end else if ((r_state != ST_DRAIN) && w_accept && s_last) begin
      r_drain_cnt <= C_DRAIN_LOAD;
    end else if ((r_state == ST_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - C_CNT_W'(1);
    end
  end

  // Beat counter: a beat taken in IDLE opens a new tile and counts as 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat_cnt <= 8'd0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_beat_cnt <= 8'd1;
      end else if (r_beat_cnt != 8'hFF) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Skew pipeline: row i is a shift register of depth i+1 that advances
  // every cycle. Cycles without an accepted beat shift in a bubble with
  // zero data, so an invalid slot always presents zero on row_data.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < n_rows; i++) begin : g_row
      logic [i:0][bit_width-1:0] r_dat;
      logic [i:0]                r_vld;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_dat <= '0;
          r_vld <= '0;
        end else begin
          r_dat[0] <= w_accept ? s_data[i*bit_width +: bit_width] : '0;
          r_vld[0] <= w_accept;
          for (int k = 1; k <= i; k++) begin
            r_dat[k] <= r_dat[k-1];
            r_vld[k] <= r_vld[k-1];
          end
        end
      end

      assign row_data[i*bit_width +: bit_width] = r_dat[i];
      assign row_valid[i]                       = r_vld[i];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mxu_data_setup.sv
`default_nettype none
// ============================================================================
// Module   : tb_mxu_data_setup
// Purpose  : Self-checking bench for mxu_data_setup (n_rows=4, bit_width=4).
//            A table of hand-derived vectors covers single-beat, back-to-back
//            and gapped tiles; directed sequences cover held-valid during
//            drain, mid-tile reset and beat counter saturation; random
//            traffic is compared against a cycle-indexed schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mxu_data_setup;

  localparam int BW = 4;
  localparam int NR = 4;
  localparam int SL = 16;

  logic             clk;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [NR*BW-1:0] s_data;
  logic             s_last;
  logic [NR*BW-1:0] row_data;
  logic [NR-1:0]    row_valid;
  logic             mac_ce;
  logic             busy;
  logic             done;
  logic [7:0]       beat_cnt;

  mxu_data_setup #(
    .bit_width (BW),
    .n_rows    (NR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .row_data  (row_data),
    .row_valid (row_valid),
    .mac_ce    (mac_ce),
    .busy      (busy),
    .done      (done),
    .beat_cnt  (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: each accepted beat schedules its row operands into a
  // cycle-indexed table; drain/tile status derives from the last-beat cycle.
  // --------------------------------------------------------------------------
  int         cyc;
  int         drain_end;
  bit         tile_open;
  int         m_cnt;
  logic [BW-1:0] sched_d [SL][NR];
  bit            sched_v [SL][NR];

  task automatic model_clear();
    cyc       = 0;
    drain_end = -1;
    tile_open = 1'b0;
    m_cnt     = 0;
    for (int s = 0; s < SL; s++)
      for (int i = 0; i < NR; i++) begin
        sched_d[s][i] = '0;
        sched_v[s][i] = 1'b0;
      end
  endtask

  function automatic bit model_draining();
    return (drain_end >= 0) && (cyc > drain_end - NR) && (cyc <= drain_end);
  endfunction

  task automatic model_update(input bit acc, input logic [NR*BW-1:0] d, input bit last);
    int s;
    int t;
    s = cyc % SL;
    for (int i = 0; i < NR; i++) begin
      sched_d[s][i] = '0;
      sched_v[s][i] = 1'b0;
    end
    if (acc) begin
      for (int i = 0; i < NR; i++) begin
        t = (cyc + 1 + i) % SL;
        sched_d[t][i] = d[i*BW +: BW];
        sched_v[t][i] = 1'b1;
      end
      if (!tile_open) m_cnt = 1;
      else if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (last) begin
        drain_end = cyc + NR;
        tile_open = 1'b0;
      end else begin
        tile_open = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic check_model();
    int s;
    logic [NR*BW-1:0] erd;
    logic [NR-1:0]    erv;
    bit dr;
    s = cyc % SL;
    for (int i = 0; i < NR; i++) begin
      erd[i*BW +: BW] = sched_d[s][i];
      erv[i]          = sched_v[s][i];
    end
    dr = model_draining();
    chk("row_data",  32'(row_data),  32'(erd));
    chk("row_valid", 32'(row_valid), 32'(erv));
    chk("mac_ce",    32'(mac_ce),    32'(|erv));
    chk("s_ready",   32'(s_ready),   32'(!dr));
    chk("busy",      32'(busy),      32'(tile_open || dr));
    chk("done",      32'(done),      32'(drain_end == cyc));
    chk("beat_cnt",  32'(beat_cnt),  32'(m_cnt));
  endtask

  // Inputs are stable from just after one rising edge to the next.
  task automatic finish_cycle();
    bit acc;
    acc = s_valid && !model_draining();
    @(posedge clk);
    #1;
    model_update(acc, s_data, s_last);
  endtask

  task automatic step_model();
    @(negedge clk);
    check_model();
    finish_cycle();
  endtask

  task automatic drive(input bit v, input bit l, input logic [NR*BW-1:0] d);
    s_valid = v;
    s_last  = l;
    s_data  = d;
  endtask

  task automatic reset_checks();
    chk("rst_row_data",  32'(row_data),  32'h0);
    chk("rst_row_valid", 32'(row_valid), 32'h0);
    chk("rst_mac_ce",    32'(mac_ce),    32'h0);
    chk("rst_s_ready",   32'(s_ready),   32'h1);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_done",      32'(done),      32'h0);
    chk("rst_beat_cnt",  32'(beat_cnt),  32'h0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0);
    reset = 1'b0;
    #1;
    reset_checks();
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  // Hand-derived vectors; outputs are those seen in the same cycle the
  // inputs are presented (before the edge that samples them).
  // --------------------------------------------------------------------------
  typedef struct {
    bit               v;
    bit               l;
    logic [NR*BW-1:0] d;
    logic [NR*BW-1:0] e_rd;
    logic [NR-1:0]    e_rv;
    bit               e_rdy;
    bit               e_busy;
    bit               e_done;
    logic [7:0]       e_cnt;
  } vec_t;

  vec_t vecs [20];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

  initial begin : main
    // single beat 0x4321
    vecs[0]  = '{1'b1, 1'b1, 16'h4321, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 16'h0001, 4'b0001, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[2]  = '{1'b0, 1'b0, 16'h0000, 16'h0020, 4'b0010, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[3]  = '{1'b0, 1'b0, 16'h0000, 16'h0300, 4'b0100, 1'b0, 1'b1, 1'b0, 8'd1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 16'h4000, 4'b1000, 1'b0, 1'b1, 1'b1, 8'd1};
    // three back-to-back beats
    vecs[5]  = '{1'b1, 1'b0, 16'h1111, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[6]  = '{1'b1, 1'b0, 16'h2222, 16'h0001, 4'b0001, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[7]  = '{1'b1, 1'b1, 16'h3333, 16'h0012, 4'b0011, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0123, 4'b0111, 1'b0, 1'b1, 1'b0, 8'd3};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h1230, 4'b1110, 1'b0, 1'b1, 1'b0, 8'd3};
    vecs[10] = '{1'b0, 1'b0, 16'h0000, 16'h2300, 4'b1100, 1'b0, 1'b1, 1'b0, 8'd3};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h3000, 4'b1000, 1'b0, 1'b1, 1'b1, 8'd3};
    // 0xAAAA, gap, 0xBBBB(last)
    vecs[12] = '{1'b1, 1'b0, 16'hAAAA, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 8'd3};
    vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'h000A, 4'b0001, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[14] = '{1'b1, 1'b1, 16'hBBBB, 16'h00A0, 4'b0010, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[15] = '{1'b0, 1'b0, 16'h0000, 16'h0A0B, 4'b0101, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[16] = '{1'b0, 1'b0, 16'h0000, 16'hA0B0, 4'b1010, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[17] = '{1'b0, 1'b0, 16'h0000, 16'h0B00, 4'b0100, 1'b0, 1'b1, 1'b0, 8'd2};
    vecs[18] = '{1'b0, 1'b0, 16'h0000, 16'hB000, 4'b1000, 1'b0, 1'b1, 1'b1, 8'd2};
    vecs[19] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000, 1'b1, 1'b0, 1'b0, 8'd2};

    reset = 1'b0;
    drive(1'b0, 1'b0, '0);
    #2;
    reset_checks();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();

    // table: first beat lands on the first edge after release
    for (int k = 0; k < 20; k++) begin
      drive(vecs[k].v, vecs[k].l, vecs[k].d);
      @(negedge clk);
      chk($sformatf("tbl%0d_row_data", k),  32'(row_data),  32'(vecs[k].e_rd));
      chk($sformatf("tbl%0d_row_valid", k), 32'(row_valid), 32'(vecs[k].e_rv));
      chk($sformatf("tbl%0d_mac_ce", k),    32'(mac_ce),    32'(|vecs[k].e_rv));
      chk($sformatf("tbl%0d_s_ready", k),   32'(s_ready),   32'(vecs[k].e_rdy));
      chk($sformatf("tbl%0d_busy", k),      32'(busy),      32'(vecs[k].e_busy));
      chk($sformatf("tbl%0d_done", k),      32'(done),      32'(vecs[k].e_done));
      chk($sformatf("tbl%0d_beat_cnt", k),  32'(beat_cnt),  32'(vecs[k].e_cnt));
      finish_cycle();
    end

    // s_valid held through drain: next beat taken on the first IDLE edge
    drive(1'b1, 1'b1, 16'h4321);
    step_model();
    drive(1'b1, 1'b1, 16'h5678);
    for (int k = 0; k < 5; k++) step_model();
    chk("held_beat_taken", 32'(busy), 32'h1);
    drive(1'b0, 1'b0, '0);
    for (int k = 0; k < 6; k++) step_model();

    // reset during the third cycle of a back-to-back tile
    drive(1'b1, 1'b0, 16'h1111);
    step_model();
    drive(1'b1, 1'b0, 16'h2222);
    step_model();
    drive(1'b1, 1'b1, 16'h3333);
    do_reset();
    drive(1'b1, 1'b1, 16'h4321);
    step_model();
    drive(1'b0, 1'b0, '0);
    for (int k = 0; k < 6; k++) step_model();
    chk("post_reset_cnt", 32'(beat_cnt), 32'd1);

    // beat counter saturation
    drive(1'b1, 1'b0, 16'h0F0F);
    for (int k = 0; k < 300; k++) step_model();
    drive(1'b1, 1'b1, 16'hF0F0);
    step_model();
    drive(1'b0, 1'b0, '0);
    for (int k = 0; k < 6; k++) step_model();
    chk("sat_cnt", 32'(beat_cnt), 32'd255);

    // random traffic
    for (int k = 0; k < 500; k++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0), 16'($urandom));
      step_model();
    end
    drive(1'b0, 1'b0, '0);
    for (int k = 0; k < 8; k++) step_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
